// File: rtl/alu_op_responder.sv
// Handshaked 4-bit ALU responder: one operation in flight at a time.
// Multiply runs as a 4-step shift-add; results drain through a small response FIFO.
module alu_op_responder #(
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_opc,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [2:0] rsp_opc,
  output logic       busy,
  output logic [7:0] op_count
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;

  state_e          state_q;
  logic [2:0]      opc_q;
  logic [3:0]      a_q, b_q;
  logic [7:0]      acc_q;
  logic [1:0]      iter_q;
  logic [10:0]     mem_q [RSP_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic       accept, push, pop;
  logic [7:0] exec_res, mul_term, mul_sum, push_res;

  assign req_ready = (state_q == StIdle) && (count_q < CntW'(RSP_DEPTH));
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (count_q != '0);
  // Head is masked while empty so stale entries never show on the outputs.
  assign {rsp_opc, rsp_data} = rsp_valid ? mem_q[rd_ptr_q] : 11'd0;

  always_comb begin
    exec_res = 8'h00;
    case (opc_q)
      3'd0:    exec_res = {4'h0, a_q} + {4'h0, b_q};
      3'd1:    exec_res = {4'h0, a_q} - {4'h0, b_q};
      3'd3:    exec_res = {7'd0, a_q <  b_q};
      3'd4:    exec_res = {7'd0, a_q >  b_q};
      3'd5:    exec_res = {7'd0, a_q == b_q};
      3'd6:    exec_res = {7'd0, a_q <= b_q};
      3'd7:    exec_res = {7'd0, a_q >= b_q};
      default: exec_res = 8'h00;
    endcase
    mul_term = b_q[iter_q] ? ({4'h0, a_q} << iter_q) : 8'h00;
    mul_sum  = acc_q + mul_term;
    push     = (state_q == StExec) || ((state_q == StMul) && (iter_q == 2'd3));
    push_res = (state_q == StMul) ? mul_sum : exec_res;
    accept   = req_valid && req_ready;
    pop      = rsp_valid && rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      opc_q    <= 3'd0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      acc_q    <= 8'h00;
      iter_q   <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      op_count <= 8'h00;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            opc_q   <= req_opc;
            a_q     <= req_a;
            b_q     <= req_b;
            acc_q   <= 8'h00;
            iter_q  <= 2'd0;
            state_q <= (req_opc == 3'd2) ? StMul : StExec;
          end
        end
        StExec: state_q <= StIdle;
        StMul: begin
          acc_q  <= mul_sum;
          iter_q <= iter_q + 2'd1;
          if (iter_q == 2'd3) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Space was reserved at accept, so a push can never overflow.
      if (push) begin
        mem_q[wr_ptr_q] <= {opc_q, push_res};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        op_count        <= op_count + 8'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_op_responder.sv
// Bench for alu_op_responder: directed vector table, FIFO-full and reset corners,
// and randomized traffic scored against a plain-arithmetic reference model.
module tb_alu_op_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_opc;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_opc;
  logic       busy;
  logic [7:0] op_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] opc;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  alu_op_responder #(.RSP_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opc   (req_opc),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_opc   (rsp_opc),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int opc, input int a, input int b, input int exp);
    vec_t v;
    v.opc = 3'(opc);
    v.a   = 4'(a);
    v.b   = 4'(b);
    v.exp = 8'(exp);
    return v;
  endfunction

  function automatic logic [7:0] ref_alu(input int opc, input int a, input int b);
    int r;
    case (opc)
      0:       r = a + b;
      1:       r = (a - b + 256) % 256;
      2:       r = a * b;
      3:       r = (a <  b) ? 1 : 0;
      4:       r = (a >  b) ? 1 : 0;
      5:       r = (a == b) ? 1 : 0;
      6:       r = (a <= b) ? 1 : 0;
      default: r = (a >= b) ? 1 : 0;
    endcase
    return 8'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge right after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    req_opc   = o;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int busy_n = 0;
    int lat    = -1;
    int want   = (v.opc == 3'd2) ? 4 : 1;
    rsp_ready = 1'b0;
    issue(v.opc, v.a, v.b);
    for (int k = 1; k <= 10; k++) begin
      if (busy) busy_n++;
      if (rsp_valid) begin
        lat = k - 1;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(want));
    check($sformatf("vec%0d_busy", idx), 32'(busy_n), 32'(want));
    check($sformatf("vec%0d_data", idx), 32'(rsp_data), 32'(v.exp));
    check($sformatf("vec%0d_opc", idx), 32'(rsp_opc), 32'(v.opc));
    check($sformatf("vec%0d_count", idx), 32'(op_count), 32'(idx + 1));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("vec%0d_popped", idx), 32'(rsp_valid), 0);
  endtask

  task automatic run_ops(input int n, input bit allow_mul, input bit rand_ready);
    logic [10:0] q[$];
    int accepted = 0;
    int cycles   = 0;
    int o, a, b;
    while ((accepted < n || q.size() != 0) && cycles < 20000) begin
      @(negedge clk);
      o = $urandom_range(0, 7);
      while (!allow_mul && o == 2) o = $urandom_range(0, 7);
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      req_opc   = 3'(o);
      req_a     = 4'(a);
      req_b     = 4'(b);
      req_valid = (accepted < n);
      rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (req_valid && req_ready) begin
        q.push_back({3'(o), ref_alu(o, a, b)});
        accepted++;
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious_rsp", 32'(rsp_valid), 0);
        end else begin
          check("rand_rsp", 32'({rsp_opc, rsp_data}), 32'(q[0]));
          void'(q.pop_front());
        end
      end
      @(posedge clk);
      cycles++;
    end
    check("rand_drained", 32'(q.size()), 0);
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    bit spurious;

    vecs.push_back(mk(0, 1, 0, 8'h01));
    vecs.push_back(mk(1, 0, 1, 8'hFF));
    vecs.push_back(mk(2, 15, 15, 8'hE1));
    vecs.push_back(mk(0, 15, 15, 8'h1E));
    vecs.push_back(mk(1, 5, 9, 8'hFC));
    vecs.push_back(mk(2, 6, 5, 8'h1E));
    vecs.push_back(mk(3, 1, 0, 8'h00));
    vecs.push_back(mk(3, 0, 1, 8'h01));
    vecs.push_back(mk(3, 1, 1, 8'h00));
    vecs.push_back(mk(4, 1, 0, 8'h01));
    vecs.push_back(mk(4, 0, 1, 8'h00));
    vecs.push_back(mk(4, 1, 1, 8'h00));
    vecs.push_back(mk(5, 1, 0, 8'h00));
    vecs.push_back(mk(5, 0, 1, 8'h00));
    vecs.push_back(mk(5, 1, 1, 8'h01));
    vecs.push_back(mk(6, 1, 0, 8'h00));
    vecs.push_back(mk(6, 0, 1, 8'h01));
    vecs.push_back(mk(6, 1, 1, 8'h01));
    vecs.push_back(mk(7, 1, 0, 8'h01));
    vecs.push_back(mk(7, 0, 1, 8'h00));
    vecs.push_back(mk(7, 1, 1, 8'h01));

    rst       = 1'b1;
    req_valid = 1'b0;
    req_opc   = 3'd0;
    req_a     = 4'd0;
    req_b     = 4'd0;
    rsp_ready = 1'b0;
    do_reset();

    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_opc", 32'(rsp_opc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_op_count", 32'(op_count), 0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Buffer full: third request must wait for a pop; order preserved.
    do_reset();
    issue(3'd0, 4'd2, 4'd3);
    @(negedge clk);
    issue(3'd1, 4'd3, 4'd1);
    @(negedge clk);
    req_opc   = 3'd4;
    req_a     = 4'd5;
    req_b     = 4'd2;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("full_req_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    check("full_head_a", 32'({rsp_opc, rsp_data}), 32'({3'd0, 8'h05}));
    check("full_count", 32'(op_count), 2);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("after_pop_req_ready", 32'(req_ready), 1);
    check("after_pop_head_b", 32'({rsp_opc, rsp_data}), 32'({3'd1, 8'h02}));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("third_busy", 32'(busy), 1);
    @(negedge clk);
    check("third_head_still_b", 32'({rsp_opc, rsp_data}), 32'({3'd1, 8'h02}));
    check("third_count", 32'(op_count), 3);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("third_head_c", 32'({rsp_opc, rsp_data}), 32'({3'd4, 8'h01}));
    @(negedge clk);
    rsp_ready = 1'b0;
    check("drained_valid", 32'(rsp_valid), 0);

    // Reset during second multiply cycle with one buffered result.
    do_reset();
    issue(3'd0, 4'd4, 4'd4);
    @(negedge clk);
    check("pre_abort_valid", 32'(rsp_valid), 1);
    issue(3'd2, 4'd3, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_rsp_valid", 32'(rsp_valid), 0);
    check("abort_op_count", 32'(op_count), 0);
    check("abort_req_ready", 32'(req_ready), 1);
    check("abort_busy", 32'(busy), 0);
    spurious = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) spurious = 1'b1;
    end
    check("abort_no_result", 32'(spurious), 0);

    // 256 single-cycle ops: op_count wraps back to zero.
    do_reset();
    run_ops(256, 1'b0, 1'b0);
    check("wrap_op_count", 32'(op_count), 0);

    // Mixed random traffic with random back-pressure.
    do_reset();
    run_ops(150, 1'b1, 1'b1);
    check("rand_op_count", 32'(op_count), 150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
